// File: rtl/psum_drain.sv
// ---------------------------------------------------------------------------
// psum_drain
//
// Accumulates per-cycle partial sums from a SIZE x SIZE PE array into an
// accumulator array. When the last beat of a tile is accepted, the
// post-accumulation tile is copied into a separate drain buffer and streamed
// out one row per cycle. Accumulation of the next tile continues while the
// previous one drains.
//
// Ports
//   clock, rst     : single clock, synchronous active-high reset
//   psums_in       : [row m][col n] partial sums, PSUM_WID bits each
//   in_valid       : psums_in carries a beat
//   in_last        : current beat closes the tile
//   in_ready       : beat accepted when in_valid & in_ready
//   out_data       : one drained row (SIZE elements)
//   out_row        : row index of out_data
//   out_valid      : out_data/out_row/out_last valid
//   out_last       : high with the final row of a tile
//   out_ready      : downstream accepts the row when out_valid & out_ready
//   tile_cnt       : tiles fully drained since reset (wraps at 2^16)
//   drain_state    : debug view of the drain FSM (1 = DRAIN, 0 = EMPTY)
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. While out_valid is high and out_ready is low, out_data,
// out_row and out_last hold. Non-last input beats are always accepted; a
// last beat waits only while the drain buffer still holds an undrained tile
// that is not leaving this cycle.
// ---------------------------------------------------------------------------
module psum_drain #(
    parameter  int SIZE     = 8,
    parameter  int PSUM_WID = 48,
    localparam int ROW_W    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                                    clock,
    input  logic                                    rst,
    input  logic [SIZE-1:0][SIZE-1:0][PSUM_WID-1:0] psums_in,
    input  logic                                    in_valid,
    input  logic                                    in_last,
    output logic                                    in_ready,
    output logic [SIZE-1:0][PSUM_WID-1:0]           out_data,
    output logic [ROW_W-1:0]                        out_row,
    output logic                                    out_valid,
    output logic                                    out_last,
    input  logic                                    out_ready,
    output logic [15:0]                             tile_cnt,
    output logic                                    drain_state
);

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SIZE - 1);

    state_t state;
    state_t state_next;

    logic [SIZE-1:0][SIZE-1:0][PSUM_WID-1:0] acc;
    logic [SIZE-1:0][SIZE-1:0][PSUM_WID-1:0] acc_next;
    logic [SIZE-1:0][SIZE-1:0][PSUM_WID-1:0] drain_buf;
    logic [ROW_W-1:0]                        row;
    logic                                    first;

    logic out_fire;
    logic busy;
    logic in_accept;
    logic load;

    // Handshake decode and next-state logic.
    always_comb begin
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_fire   = 1'b0;
        busy       = 1'b0;
        in_ready   = 1'b1;
        in_accept  = 1'b0;
        load       = 1'b0;
        state_next = state;

        out_valid = (state == DRAIN);
        out_last  = out_valid && (row == LAST_ROW);
        out_fire  = out_valid && out_ready;
        // The buffer is free for a new tile if empty, or if its final row
        // leaves on this very edge (zero-bubble reload).
        busy      = out_valid && !(out_fire && out_last);
        in_ready  = !(in_last && busy);
        in_accept = in_valid && in_ready;
        load      = in_accept && in_last;

        if (load) begin
            state_next = DRAIN;
        end else if (out_fire && out_last) begin
            state_next = EMPTY;
        end
    end

    // First beat of a tile overwrites; later beats add with wraparound.
    always_comb begin
        acc_next = '0;
        for (int m = 0; m < SIZE; m++) begin
            for (int n = 0; n < SIZE; n++) begin
                if (first) begin
                    acc_next[m][n] = psums_in[m][n];
                end else begin
                    acc_next[m][n] = acc[m][n] + psums_in[m][n];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            acc       <= '0;
            drain_buf <= '0;
            first     <= 1'b1;
            row       <= '0;
            tile_cnt  <= '0;
        end else begin
            if (in_accept) begin
                acc   <= acc_next;
                first <= in_last;
            end

            // After the final row the pointer stays on SIZE-1 so out_data and
            // out_row keep showing the last drained row while EMPTY.
            if (load) begin
                drain_buf <= acc_next;
                row       <= '0;
            end else if (out_fire && !out_last) begin
                row <= row + ROW_W'(1);
            end

            if (out_fire && out_last) begin
                tile_cnt <= tile_cnt + 16'd1;
            end
        end
    end

    assign out_data    = drain_buf[row];
    assign out_row     = row;
    assign drain_state = (state == DRAIN);

endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;

    localparam int SIZE  = 8;
    localparam int W     = 48;
    localparam int ROW_W = 3;
    localparam int EW    = ROW_W + SIZE * W;

    logic                           clock;
    logic                           rst;
    logic [SIZE-1:0][SIZE-1:0][W-1:0] psums_in;
    logic                           in_valid;
    logic                           in_last;
    logic                           in_ready;
    logic [SIZE-1:0][W-1:0]         out_data;
    logic [ROW_W-1:0]               out_row;
    logic                           out_valid;
    logic                           out_last;
    logic                           out_ready;
    logic [15:0]                    tile_cnt;
    logic                           drain_state;

    psum_drain #(.SIZE(SIZE), .PSUM_WID(W)) dut (
        .clock       (clock),
        .rst         (rst),
        .psums_in    (psums_in),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .tile_cnt    (tile_cnt),
        .drain_state (drain_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model / scoreboard ----------------
    // Each queued entry is one expected output row: {row index, row data}.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_shown;
    logic [W-1:0]  m_sum[SIZE][SIZE];
    logic          m_first;
    logic [15:0]   m_cnt;
    logic          last_accepted;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic timeout_fail(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_shown = '0;
        m_first    = 1'b1;
        m_cnt      = '0;
        for (int m = 0; m < SIZE; m++)
            for (int n = 0; n < SIZE; n++)
                m_sum[m][n] = '0;
    endtask

    // One clock cycle: check outputs against the model with the current
    // inputs, advance the model across the coming edge, then cross the edge.
    task automatic step();
        logic [EW-1:0]          cur;
        logic                   has;
        logic                   exp_rdy;
        int                     cur_row;
        logic [SIZE-1:0][W-1:0] rd;
        logic [EW-1:0]          popped;

        @(negedge clock);
        has     = (exp_q.size() > 0);
        cur     = has ? exp_q[0] : last_shown;
        cur_row = int'(cur[EW-1 -: ROW_W]);
        // A last beat must wait while a tile is still pending, unless that
        // tile's final row is being taken right now.
        exp_rdy = !(in_last && has && !(out_ready && cur_row == SIZE - 1));

        check("in_ready",  512'(in_ready),  512'(exp_rdy));
        check("out_valid", 512'(out_valid), 512'(has));
        check("out_last",  512'(out_last),  512'(has && cur_row == SIZE - 1));
        check("out_data",  512'(out_data),  512'(cur[SIZE*W-1:0]));
        check("out_row",   512'(out_row),   512'(cur_row));
        check("tile_cnt",  512'(tile_cnt),  512'(m_cnt));

        last_accepted = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (has && out_ready) begin
                popped     = exp_q.pop_front();
                last_shown = popped;
                if (int'(popped[EW-1 -: ROW_W]) == SIZE - 1) m_cnt = m_cnt + 16'd1;
            end
            if (in_valid && exp_rdy) begin
                for (int m = 0; m < SIZE; m++)
                    for (int n = 0; n < SIZE; n++)
                        m_sum[m][n] = m_first ? psums_in[m][n] : m_sum[m][n] + psums_in[m][n];
                m_first = in_last;
                if (in_last) begin
                    last_accepted = 1'b1;
                    for (int r = 0; r < SIZE; r++) begin
                        for (int n = 0; n < SIZE; n++) rd[n] = m_sum[r][n];
                        exp_q.push_back({ROW_W'(r), rd});
                    end
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_all(input logic [W-1:0] v);
        for (int m = 0; m < SIZE; m++)
            for (int n = 0; n < SIZE; n++)
                psums_in[m][n] = v;
    endtask

    task automatic fill_rand();
        logic [63:0] r64;
        for (int m = 0; m < SIZE; m++)
            for (int n = 0; n < SIZE; n++) begin
                r64 = {$urandom(), $urandom()};
                // Occasionally push values near the top to force wraps.
                if ($urandom_range(0, 3) == 0) r64[W-1:W-8] = 8'hff;
                psums_in[m][n] = r64[W-1:0];
            end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_row(input int r);
        int i;
        for (i = 0; i < 40; i++) begin
            if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: ROW_W]) == r) break;
            step();
        end
        if (i == 40) timeout_fail("wait_row");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        fill_all('0);
        last_accepted = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (2) step();                       // reset state

        // Three beats of 5 -> every element 15, rows on consecutive cycles.
        out_ready = 1'b1;
        fill_all(48'd5);
        in_valid = 1'b1;
        step();
        step();
        in_last = 1'b1;
        step();
        idle_in();
        repeat (10) step();

        // Wraparound: all-ones + 2 -> 1.
        fill_all('1);
        in_valid = 1'b1;
        step();
        fill_all(48'd2);
        in_last = 1'b1;
        step();
        idle_in();
        repeat (10) step();

        // Back-pressure for 4 cycles on row 2.
        fill_rand();
        in_valid = 1'b1;
        step();
        fill_rand();
        in_last = 1'b1;
        step();
        idle_in();
        wait_row(2);
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        repeat (10) step();

        // Next tile accumulates during drain; its last beat stalls until
        // the final row of the current tile leaves, then reloads bubble-free.
        fill_rand();
        in_valid = 1'b1;
        in_last  = 1'b1;
        step();
        idle_in();
        wait_row(4);
        out_ready = 1'b0;
        fill_rand();
        in_valid = 1'b1;
        step();
        fill_rand();
        step();
        fill_rand();
        in_last = 1'b1;
        repeat (3) step();
        out_ready = 1'b1;
        begin
            int i;
            for (i = 0; i < 20; i++) begin
                step();
                if (last_accepted) break;
            end
            if (i == 20) timeout_fail("last_beat_accept");
        end
        idle_in();
        repeat (12) step();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            fill_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_in();
        out_ready = 1'b1;
        repeat (12) step();

        // Reset during drain of row 3, then a fresh single-beat tile of 7.
        fill_all(48'd9);
        in_valid = 1'b1;
        in_last  = 1'b1;
        step();
        idle_in();
        wait_row(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();
        fill_all(48'd7);
        in_valid = 1'b1;
        in_last  = 1'b1;
        step();
        idle_in();
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
